ts_phase_scheduler: RTL and testbench

Four-approach traffic phase scheduler for an intersection controller. It latches vehicle-detector requests per approach and grants green to one approach at a time in round-robin order. Each grant goes through a GREEN -> YELLOW -> ALL-RED sequence with programmable timing. Approach 0 is the default (highway) phase and rests in green when no other approach requests.

---
 rtl/ts_phase_scheduler.sv | 150 +++++++++++++++
 tb/tb_ts_phase_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_phase_scheduler.sv
`default_nettype none
// ==========================================================================
// ts_phase_scheduler : four-approach round-robin traffic phase scheduler
// Revision 1.0 : initial release
// ==========================================================================
module ts_phase_scheduler #(
  parameter int CNT_W     = 8,
  parameter int MIN_GREEN = 10,
  parameter int MAX_GREEN = 40,
  parameter int YELLOW_T  = 4,
  parameter int ALLRED_T  = 2
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [3:0] sensor,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic [3:0] red,
  output logic [1:0] active_phase,
  output logic [3:0] req_pending
);

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST    = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);

  generate
    if (MIN_GREEN < 1 || MAX_GREEN < MIN_GREEN || MAX_GREEN >= (1 << CNT_W) ||
        YELLOW_T < 1 || ALLRED_T < 1 || YELLOW_T > (1 << CNT_W) ||
        ALLRED_T > (1 << CNT_W)) begin : g_param_check
      $error("ts_phase_scheduler: illegal timing parameters");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       cur_q, cur_d;
  logic [3:0]       pending_q, pending_d;
  logic [3:0]       green_q, green_d;
  logic [3:0]       yellow_q, yellow_d;
  logic [3:0]       red_q, red_d;

  logic [3:0] cur_onehot;
  logic [3:0] served_mask;
  logic [3:0] lamp_sel;
  logic       other_waiting;
  logic [1:0] next_sel;
  logic [1:0] cand;
  logic       next_found;

  assign cur_onehot    = 4'b0001 << cur_q;
  assign other_waiting = |(pending_q & ~cur_onehot);

  // Rotating priority: cur+1, cur+2, cur+3, then cur itself last.
  always_comb begin : p_select
    next_sel   = cur_q;
    next_found = 1'b0;
    cand       = cur_q;
    for (int k = 1; k <= 4; k++) begin
      cand = cur_q + 2'(k);
      if (!next_found && pending_q[cand]) begin
        next_sel   = cand;
        next_found = 1'b1;
      end
    end
  end

  always_comb begin : p_next
    state_d     = state_q;
    cur_d       = cur_q;
    timer_d     = timer_q;
    served_mask = (state_q == ST_GREEN) ? cur_onehot : 4'b0000;
    pending_d   = pending_q | (sensor & ~served_mask);

    case (state_q)
      ST_ALLRED: begin
        if (timer_q == ALLRED_LAST) begin
          state_d             = ST_GREEN;
          cur_d               = next_sel;
          pending_d[next_sel] = 1'b0;
        end
      end
      ST_GREEN: begin
        if (other_waiting &&
            ((timer_q >= MIN_LAST && !sensor[cur_q]) || timer_q == MAX_LAST)) begin
          state_d = ST_YELLOW;
        end
      end
      ST_YELLOW: begin
        if (timer_q == YELLOW_LAST) begin
          state_d = ST_ALLRED;
        end
      end
      default: begin
        state_d = ST_ALLRED;
      end
    endcase

    // Green timer saturates so a resting phase never wraps back below MIN_GREEN.
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (state_q == ST_GREEN && timer_q == MAX_LAST) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + CNT_W'(1);
    end
  end

  always_comb begin : p_lamps
    lamp_sel = 4'b0001 << cur_d;
    green_d  = (state_d == ST_GREEN)  ? lamp_sel : 4'b0000;
    yellow_d = (state_d == ST_YELLOW) ? lamp_sel : 4'b0000;
    red_d    = ~(green_d | yellow_d);
  end

  always_ff @(posedge clk or posedge clear) begin : p_regs
    if (clear) begin
      state_q   <= ST_ALLRED;
      timer_q   <= '0;
      cur_q     <= 2'd0;
      pending_q <= 4'b0000;
      green_q   <= 4'b0000;
      yellow_q  <= 4'b0000;
      red_q     <= 4'b1111;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      cur_q     <= cur_d;
      pending_q <= pending_d;
      green_q   <= green_d;
      yellow_q  <= yellow_d;
      red_q     <= red_d;
    end
  end

  assign green        = green_q;
  assign yellow       = yellow_q;
  assign red          = red_q;
  assign active_phase = cur_q;
  assign req_pending  = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_ts_phase_scheduler.sv
`default_nettype none
// ==========================================================================
// tb_ts_phase_scheduler : directed self-checking bench for ts_phase_scheduler
// Revision 1.0 : initial release
// ==========================================================================
module tb_ts_phase_scheduler;

  logic       clk = 1'b0;
  logic       clear;
  logic [3:0] sensor;
  logic [3:0] green, yellow, red, req_pending;
  logic [1:0] active_phase;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  ts_phase_scheduler #(
    .CNT_W(8), .MIN_GREEN(10), .MAX_GREEN(40), .YELLOW_T(4), .ALLRED_T(2)
  ) dut (
    .clk(clk),
    .clear(clear),
    .sensor(sensor),
    .green(green),
    .yellow(yellow),
    .red(red),
    .active_phase(active_phase),
    .req_pending(req_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every approach shows exactly one lamp, and at most one approach is non-red.
  always @(negedge clk) begin
    if (started) begin
      logic ok;
      int nonred;
      ok = 1'b1;
      nonred = 0;
      for (int i = 0; i < 4; i++) begin
        if ((int'(red[i]) + int'(yellow[i]) + int'(green[i])) != 1) ok = 1'b0;
        if (!red[i]) nonred++;
      end
      if (nonred > 1) ok = 1'b0;
      chk("lamp_invariant", {31'd0, ok}, 32'd1);
    end
  end

  task automatic startup();
    clear  = 1'b1;
    sensor = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_red", red, 4'b1111);
      chk("rst_green", green, 4'b0000);
    end
    clear = 1'b0;
    tick();
    chk("start_e1_green", green, 4'b0000);
    chk("start_e1_red", red, 4'b1111);
    tick();
    chk("start_e2_green", green, 4'b0001);
    chk("start_e2_phase", active_phase, 2'd0);
  endtask

  initial begin
    clear  = 1'b1;
    sensor = 4'b0000;
    @(posedge clk);
    started = 1'b1;

    // Startup and idle rest on approach 0
    startup();
    for (int i = 0; i < 200; i++) begin
      tick();
      chk("idle_green", green, 4'b0001);
      chk("idle_yellow", yellow, 4'b0000);
      chk("idle_pend", req_pending, 4'b0000);
    end

    // Gap-out: fresh green0 entry at E0, approach 2 requests at E3
    startup();
    tick(); tick();
    sensor = 4'b0100;
    tick();
    sensor = 4'b0000;
    chk("gap_pend", req_pending, 4'b0100);
    chk("gap_green3", green, 4'b0001);
    for (int k = 4; k <= 9; k++) begin
      tick();
      chk("gap_green", green, 4'b0001);
      chk("gap_pend_hold", req_pending, 4'b0100);
    end
    for (int k = 10; k <= 13; k++) begin
      tick();
      chk("gap_yellow", yellow, 4'b0001);
      chk("gap_yel_green", green, 4'b0000);
    end
    for (int k = 14; k <= 15; k++) begin
      tick();
      chk("gap_allred", red, 4'b1111);
    end
    tick();
    chk("gap_grant_green", green, 4'b0100);
    chk("gap_grant_phase", active_phase, 2'd2);
    chk("gap_grant_pend", req_pending, 4'b0000);

    // Max-out: hold sensor0 to pull green back to 0, then pulse approach 1
    sensor = 4'b0001;
    for (int k = 17; k <= 25; k++) begin
      tick();
      chk("mx_g2", green, 4'b0100);
      if (k == 17) chk("mx_pend0", req_pending, 4'b0001);
    end
    for (int k = 26; k <= 29; k++) begin
      tick();
      chk("mx_y2", yellow, 4'b0100);
    end
    for (int k = 30; k <= 31; k++) begin
      tick();
      chk("mx_ar2", red, 4'b1111);
    end
    tick();
    chk("mx_g0_green", green, 4'b0001);
    chk("mx_g0_phase", active_phase, 2'd0);
    chk("mx_g0_pend_clear_wins", req_pending, 4'b0000);
    tick();
    sensor = 4'b0011;
    tick();
    sensor = 4'b0001;
    chk("mx_pend1", req_pending, 4'b0010);
    chk("mx_g0_34", green, 4'b0001);
    for (int k = 35; k <= 71; k++) begin
      tick();
      chk("mx_g0_hold", green, 4'b0001);
    end
    tick();
    sensor = 4'b0000;
    chk("mx_y0", yellow, 4'b0001);
    for (int k = 73; k <= 75; k++) begin
      tick();
      chk("mx_y0_hold", yellow, 4'b0001);
    end
    for (int k = 76; k <= 77; k++) begin
      tick();
      chk("mx_ar0", red, 4'b1111);
    end
    tick();
    chk("mx_g1_green", green, 4'b0010);
    chk("mx_g1_phase", active_phase, 2'd1);
    chk("mx_g1_pend", req_pending, 4'b0000);

    // Round robin: requests on 0 and 3 during green1 -> 3 then 0
    tick(); tick();
    sensor = 4'b1001;
    tick();
    sensor = 4'b0000;
    chk("rr_pend", req_pending, 4'b1001);
    for (int k = 82; k <= 87; k++) begin
      tick();
      chk("rr_g1", green, 4'b0010);
    end
    for (int k = 88; k <= 91; k++) begin
      tick();
      chk("rr_y1", yellow, 4'b0010);
    end
    for (int k = 92; k <= 93; k++) begin
      tick();
      chk("rr_ar1", red, 4'b1111);
    end
    tick();
    chk("rr_g3_green", green, 4'b1000);
    chk("rr_g3_phase", active_phase, 2'd3);
    chk("rr_g3_pend", req_pending, 4'b0001);
    for (int k = 95; k <= 103; k++) begin
      tick();
      chk("rr_g3", green, 4'b1000);
    end
    for (int k = 104; k <= 107; k++) begin
      tick();
      chk("rr_y3", yellow, 4'b1000);
    end
    for (int k = 108; k <= 109; k++) begin
      tick();
      chk("rr_ar3", red, 4'b1111);
    end
    tick();
    chk("rr_g0_green", green, 4'b0001);
    chk("rr_g0_phase", active_phase, 2'd0);
    chk("rr_g0_pend", req_pending, 4'b0000);

    // Reset mid-operation during yellow cycle 2
    sensor = 4'b0010;
    tick();
    sensor = 4'b0000;
    chk("mr_pend", req_pending, 4'b0010);
    for (int k = 112; k <= 119; k++) begin
      tick();
      chk("mr_g0", green, 4'b0001);
    end
    tick();
    chk("mr_y0_first", yellow, 4'b0001);
    tick();
    chk("mr_y0_second", yellow, 4'b0001);
    #2;
    clear = 1'b1;
    #1;
    chk("mr_async_red", red, 4'b1111);
    chk("mr_async_yellow", yellow, 4'b0000);
    chk("mr_async_green", green, 4'b0000);
    chk("mr_async_pend", req_pending, 4'b0000);
    startup();
    tick();
    chk("mr_after_green", green, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
